fifo_read_arbiter: RTL and testbench

FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_read_arbiter_rr_pick.sv | 25 ++
 rtl/fifo_read_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_read_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared defaults and helpers for the FIFO read arbiter.
package fifo_arb_pkg;

    localparam int DEF_DATA_WIDTH = 88;
    localparam int DEF_NUM_FIFOS  = 4;
    localparam int DEF_MAX_BURST  = 8;
    localparam int BUF_DEPTH      = 2;

    // Width of a FIFO source index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after cur, wrapping, cur itself last.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] cur,
    output logic [IW-1:0] nxt,
    output logic          any
);

    int j;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        nxt = cur;
        any = |req;
        j   = 0;
        for (int i = N; i >= 1; i--) begin
            j = (int'(cur) + i) % N;
            if (req[j[IW-1:0]]) nxt = j[IW-1:0];
        end
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Burst-limited round-robin reader of several async-FIFO read ports into a
// 2-entry in-order output buffer tagged with the source index.
module fifo_read_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_FIFOS  = DEF_NUM_FIFOS,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                            RClk,
    input  logic                            PresetFull,
    input  logic                            enable_i,
    input  logic [NUM_FIFOS-1:0]            fifo_empty_i,
    output logic [NUM_FIFOS-1:0]            fifo_rden_o,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic [idx_width(NUM_FIFOS)-1:0] out_src_o,
    output logic                            busy_o
);

    localparam int IW = idx_width(NUM_FIFOS);
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [IW-1:0]         gnt, pick, sel, inf_src;
    logic [BW-1:0]         burst;
    logic                  pick_any, stay, inflight, issue, pop;
    logic [1:0]            occ;
    logic [2:0]            level;
    logic [DATA_WIDTH-1:0] slice    [NUM_FIFOS];
    logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
    logic [IW-1:0]         buf_src  [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] cap_data;

    for (genvar k = 0; k < NUM_FIFOS; k++) begin : g_slice
        assign slice[k] = fifo_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(.N(NUM_FIFOS), .IW(IW)) u_pick (
        .req (~fifo_empty_i),
        .cur (gnt),
        .nxt (pick),
        .any (pick_any)
    );

    assign pop      = (occ != 2'd0) && out_ready_i;
    assign stay     = !fifo_empty_i[gnt] && (burst < BW'(MAX_BURST));
    assign cap_data = slice[inf_src];

    // Occupancy counts this cycle's pop so a steady consumer sees no bubble.
    always_comb begin
        sel         = stay ? gnt : pick;
        level       = 3'(occ) + 3'(inflight) - 3'(pop);
        issue       = !PresetFull && enable_i && (stay || pick_any) && (level < 3'd2);
        fifo_rden_o = '0;
        if (issue) fifo_rden_o[sel] = 1'b1;
    end

    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            gnt      <= '0;
            burst    <= '0;
            inflight <= 1'b0;
            inf_src  <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inf_src <= sel;
                gnt     <= sel;
                burst   <= stay ? burst + BW'(1) : BW'(1);
            end
        end
    end

    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            occ <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_src[i]  <= '0;
            end
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    buf_data[occ[0]] <= cap_data;
                    buf_src[occ[0]]  <= inf_src;
                    occ              <= occ + 2'd1;
                end
                2'b01: begin
                    buf_data[0] <= buf_data[1];
                    buf_src[0]  <= buf_src[1];
                    occ         <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf_data[0] <= cap_data;
                        buf_src[0]  <= inf_src;
                    end else begin
                        buf_data[0] <= buf_data[1];
                        buf_src[0]  <= buf_src[1];
                        buf_data[1] <= cap_data;
                        buf_src[1]  <= inf_src;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid_o = (occ != 2'd0);
    assign out_data_o  = buf_data[0];
    assign out_src_o   = buf_src[0];
    assign busy_o      = inflight || (occ != 2'd0);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed scoreboard bench for fifo_read_arbiter with behavioural FIFO read ports.
module tb_fifo_read_arbiter;
    import fifo_arb_pkg::*;

    localparam int NF = 4;
    localparam int DW = 88;
    localparam int IW = 2;

    logic           RClk = 1'b0;
    logic           PresetFull = 1'b1;
    logic           enable = 1'b0;
    logic           out_ready = 1'b0;
    logic           fifo_clr = 1'b1;
    logic [NF-1:0]  fifo_empty, fifo_rden;
    logic [NF*DW-1:0] fifo_data;
    logic           out_valid, busy;
    logic [DW-1:0]  out_data;
    logic [IW-1:0]  out_src;

    int             avail [NF];
    int             rdptr [NF];
    logic [DW-1:0]  dreg  [NF];

    typedef struct packed {
        logic [IW-1:0] src;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d;
    logic [IW-1:0] hold_s;

    fifo_read_arbiter dut (
        .RClk         (RClk),
        .PresetFull   (PresetFull),
        .enable_i     (enable),
        .fifo_empty_i (fifo_empty),
        .fifo_rden_o  (fifo_rden),
        .fifo_data_i  (fifo_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_src_o    (out_src),
        .busy_o       (busy)
    );

    always #5 RClk = ~RClk;

    function automatic logic [DW-1:0] mkword(input int k, input int i);
        return {8'(k), 16'hC0DE, 32'(i * 7 + 3), 32'hA5A5_0000 | 32'(i)};
    endfunction

    // Behavioural FIFO read ports: registered data, one-cycle read latency.
    always @(posedge RClk or posedge fifo_clr) begin
        if (fifo_clr) begin
            for (int k = 0; k < NF; k++) begin
                rdptr[k] <= 0;
                dreg[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NF; k++) begin
                if (fifo_rden[k]) begin
                    dreg[k]  <= mkword(k, rdptr[k]);
                    rdptr[k] <= rdptr[k] + 1;
                end
            end
        end
    end

    always_comb begin
        fifo_empty = '0;
        fifo_data  = '0;
        for (int k = 0; k < NF; k++) begin
            fifo_empty[k] = (rdptr[k] >= avail[k]);
            fifo_data[k*DW +: DW] = dreg[k];
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_words(input int k, input int first, input int last);
        exp_t e;
        for (int i = first; i <= last; i++) begin
            e.src  = IW'(k);
            e.data = mkword(k, i);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: samples mid-low-phase, after stimulus has settled.
    always @(negedge RClk) begin
        exp_t e;
        #2;
        if (!PresetFull) begin
            if (fifo_rden != '0) begin
                check("rden_onehot", 128'($onehot(fifo_rden)), 128'(1));
                check("rden_on_empty", 128'(fifo_rden & fifo_empty), 128'(0));
            end
            if (hold_v) begin
                check("head_valid_hold", 128'(out_valid), 128'(1));
                check("head_data_hold", 128'(out_data), 128'(hold_d));
                check("head_src_hold", 128'(out_src), 128'(hold_s));
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_s = out_src;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got src %0d data %0h, required none", out_src, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_src", 128'(out_src), 128'(e.src));
                    check("out_data", 128'(out_data), 128'(e.data));
                end
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic begin_test(input logic en, input logic rdy);
        @(negedge RClk);
        PresetFull = 1'b1;
        fifo_clr   = 1'b1;
        for (int k = 0; k < NF; k++) avail[k] = 0;
        enable    = en;
        out_ready = rdy;
        @(negedge RClk);
        fifo_clr = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge RClk);
        PresetFull = 1'b0;
    endtask

    task automatic finish_test(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge RClk);
            n++;
        end
        repeat (5) @(negedge RClk);
        check({name, "_drained"}, 128'(exp_q.size() == 0 && !busy), 128'(1));
        exp_q.delete();
    endtask

    initial begin
        for (int k = 0; k < NF; k++) avail[k] = 0;

        // Single FIFO, three words, consumer always ready; also reset values.
        begin_test(1'b1, 1'b1);
        avail[0] = 3;
        #1;
        check("rst_rden", 128'(fifo_rden), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_data", 128'(out_data), 128'(0));
        check("rst_src", 128'(out_src), 128'(0));
        expect_words(0, 0, 2);
        release_rst();
        #1 check("t1_rden_c0", 128'(fifo_rden), 128'(4'b0001));
        @(negedge RClk); #1;
        check("t1_rden_c1", 128'(fifo_rden), 128'(4'b0001));
        check("t1_valid_c1", 128'(out_valid), 128'(0));
        @(negedge RClk); #1;
        check("t1_rden_c2", 128'(fifo_rden), 128'(4'b0001));
        check("t1_valid_c2", 128'(out_valid), 128'(1));
        @(negedge RClk); #1;
        check("t1_rden_c3", 128'(fifo_rden), 128'(4'b0000));
        check("t1_valid_c3", 128'(out_valid), 128'(1));
        finish_test("t1");

        // Burst limit and round-robin hand-off: 0 x8, 2 x2, 0 x4.
        begin_test(1'b1, 1'b1);
        avail[0] = 12;
        avail[2] = 2;
        expect_words(0, 0, 7);
        expect_words(2, 0, 1);
        expect_words(0, 8, 11);
        release_rst();
        finish_test("t2");

        // Back-pressure with full buffer, then drain and resume.
        begin_test(1'b1, 1'b0);
        avail[1] = 4;
        expect_words(1, 0, 3);
        release_rst();
        repeat (3) @(negedge RClk);
        for (int c = 0; c < 5; c++) begin
            @(negedge RClk); #1;
            check("t3_stall_rden", 128'(fifo_rden), 128'(0));
            check("t3_stall_valid", 128'(out_valid), 128'(1));
            check("t3_stall_data", 128'(out_data), 128'(mkword(1, 0)));
        end
        out_ready = 1'b1;
        #1 check("t3_resume", 128'(fifo_rden), 128'(4'b0010));
        finish_test("t3");

        // All empty, then FIFO3 becomes non-empty mid-cycle.
        begin_test(1'b1, 1'b1);
        release_rst();
        repeat (3) @(negedge RClk);
        #1;
        check("t4_idle_rden", 128'(fifo_rden), 128'(0));
        check("t4_idle_busy", 128'(busy), 128'(0));
        avail[3] = 1;
        expect_words(3, 0, 0);
        #1 check("t4_rden3", 128'(fifo_rden), 128'(4'b1000));
        @(negedge RClk); #1;
        check("t4_valid_early", 128'(out_valid), 128'(0));
        @(negedge RClk); #1;
        check("t4_valid", 128'(out_valid), 128'(1));
        check("t4_src", 128'(out_src), 128'(3));
        finish_test("t4");

        // Reset with one word buffered and one in flight.
        begin_test(1'b1, 1'b0);
        avail[2] = 5;
        release_rst();
        @(negedge RClk);
        @(negedge RClk);
        #1 check("t5_busy_pre", 128'(busy), 128'(1));
        PresetFull = 1'b1;
        #1;
        check("t5_rst_rden", 128'(fifo_rden), 128'(0));
        check("t5_rst_valid", 128'(out_valid), 128'(0));
        check("t5_rst_busy", 128'(busy), 128'(0));
        check("t5_rst_data", 128'(out_data), 128'(0));
        check("t5_rst_src", 128'(out_src), 128'(0));
        avail[1] = 1;
        expect_words(1, 0, 0);
        expect_words(2, 2, 4);
        out_ready = 1'b1;
        release_rst();
        finish_test("t5");

        // Enable dropped mid-burst: in-flight word still delivered.
        begin_test(1'b1, 1'b1);
        avail[3] = 6;
        expect_words(3, 0, 2);
        release_rst();
        repeat (3) @(negedge RClk);
        #1 enable = 1'b0;
        #1;
        check("t6_stop_rden", 128'(fifo_rden), 128'(0));
        check("t6_busy_c0", 128'(busy), 128'(1));
        @(negedge RClk); #1;
        check("t6_busy_c1", 128'(busy), 128'(1));
        @(negedge RClk); #1;
        check("t6_busy_c2", 128'(busy), 128'(0));
        finish_test("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
